axis_key_event: RTL and testbench



---
 rtl/axis_key_pkg.sv | 22 ++
 rtl/axis_key_prio_enc.sv | 24 ++
 rtl/axis_key_event.sv | 167 ++++++++++++++++
 tb/tb_axis_key_event.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_key_pkg.sv
// Shared types and constants for the AXI-stream key-event block.
package axis_key_pkg;

    typedef enum logic {
        ST_SAMPLE = 1'b0,
        ST_EMIT   = 1'b1
    } state_t;

    localparam int KEY_IDX_W       = 7;
    localparam int EVT_RELEASE_BIT = 7;

    // Bits needed to hold values 0..value-1, never less than 1.
    function automatic int clog2(input int value);
        int bits;
        bits = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            bits = bits + 1;
        end
        return (bits < 1) ? 1 : bits;
    endfunction

endpackage

// File: rtl/axis_key_prio_enc.sv
// Combinational lowest-set-bit encoder: returns the index of the lowest set bit and a found flag.
module axis_key_prio_enc
    import axis_key_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic [DATA_WIDTH-1:0] vec,
    output logic [KEY_IDX_W-1:0]  idx,
    output logic                  found
);

    // Scan from the top down so the last hit wins, leaving the lowest index.
    always_comb begin
        idx   = '0;
        found = 1'b0;
        for (int i = DATA_WIDTH - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx   = KEY_IDX_W'(i);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/axis_key_event.sv
// Debounces raw switch samples and emits one key-event word per edge, lowest key index first.
// Optional release events are enabled by defining KEY_RELEASE_EVENT_EN.
module axis_key_event
    import axis_key_pkg::*;
#(
    parameter int DATA_WIDTH       = 8,
    parameter int DEBOUNCE_SAMPLES = 4
) (
    input  logic                  axis_aclk_i,
    input  logic                  axis_aresetn_i,
    input  logic                  s_axis_tvalid_i,
    output logic                  s_axis_tready_o,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata_i,
    output logic                  m_axis_tvalid_o,
    input  logic                  m_axis_tready_i,
    output logic [7:0]            m_axis_tdata_o
);

    localparam int              CNT_W   = clog2(DEBOUNCE_SAMPLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_SAMPLES);

    state_t                state_reg, state_next;
    logic [DATA_WIDTH-1:0] last_sample_reg, last_sample_next;
    logic [DATA_WIDTH-1:0] stable_reg, stable_next;
    logic [DATA_WIDTH-1:0] pending_reg, pending_next;
    logic [CNT_W-1:0]      count_reg, count_next;
    logic                  s_tready_reg, s_tready_next;
    logic                  m_tvalid_reg, m_tvalid_next;
    logic [7:0]            m_tdata_reg, m_tdata_next;

    logic                  accept;
    logic                  m_hs;
    logic                  commit;
    logic [CNT_W-1:0]      count_upd;
    logic [DATA_WIDTH-1:0] edges;
    logic [DATA_WIDTH-1:0] pending_low;
    logic [KEY_IDX_W-1:0]  enc_idx;
    logic                  enc_found;
    logic                  release_flag;
    logic [7:0]            event_word;

    assign accept      = s_axis_tvalid_i & s_tready_reg;
    assign m_hs        = m_tvalid_reg & m_axis_tready_i;
    assign pending_low = pending_reg & (~pending_reg + DATA_WIDTH'(1));

`ifdef KEY_RELEASE_EVENT_EN
    logic [DATA_WIDTH-1:0] next_low;

    assign edges    = s_axis_tdata_i ^ stable_reg;
    assign next_low = pending_next & (~pending_next + DATA_WIDTH'(1));
    // A queued key whose new stable level is 0 went 1->0.
    assign release_flag = |(next_low & ~stable_next);
`else
    assign edges        = s_axis_tdata_i & ~stable_reg;
    assign release_flag = 1'b0;
`endif

    // The encoder looks at next-cycle pending so the event word can be registered.
    axis_key_prio_enc #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_prio_enc (
        .vec   (pending_next),
        .idx   (enc_idx),
        .found (enc_found)
    );

    always_comb begin
        event_word                  = '0;
        event_word[EVT_RELEASE_BIT] = release_flag;
        event_word[KEY_IDX_W-1:0]   = enc_idx;
    end

    // Debounce and pending-event datapath.
    always_comb begin
        last_sample_next = last_sample_reg;
        count_next       = count_reg;
        stable_next      = stable_reg;
        pending_next     = pending_reg;
        commit           = 1'b0;
        if (s_axis_tdata_i == last_sample_reg) begin
            count_upd = (count_reg == CNT_MAX) ? CNT_MAX : count_reg + CNT_W'(1);
        end else begin
            count_upd = CNT_W'(1);
        end
        case (state_reg)
            ST_SAMPLE: begin
                if (accept) begin
                    last_sample_next = s_axis_tdata_i;
                    count_next       = count_upd;
                    if (count_upd == CNT_MAX && s_axis_tdata_i != stable_reg) begin
                        commit       = 1'b1;
                        stable_next  = s_axis_tdata_i;
                        pending_next = edges;
                    end
                end
            end
            ST_EMIT: begin
                if (m_hs) begin
                    pending_next = pending_reg & ~pending_low;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        state_next    = state_reg;
        s_tready_next = s_tready_reg;
        m_tvalid_next = m_tvalid_reg;
        m_tdata_next  = m_tdata_reg;
        case (state_reg)
            ST_SAMPLE: begin
                s_tready_next = 1'b1;
                m_tvalid_next = 1'b0;
                if (commit && enc_found) begin
                    state_next    = ST_EMIT;
                    s_tready_next = 1'b0;
                    m_tvalid_next = 1'b1;
                    m_tdata_next  = event_word;
                end
            end
            ST_EMIT: begin
                s_tready_next = 1'b0;
                m_tvalid_next = 1'b1;
                if (m_hs) begin
                    if (enc_found) begin
                        m_tdata_next = event_word;
                    end else begin
                        state_next    = ST_SAMPLE;
                        s_tready_next = 1'b1;
                        m_tvalid_next = 1'b0;
                    end
                end
            end
            default: begin
                state_next = ST_SAMPLE;
            end
        endcase
    end

    always_ff @(posedge axis_aclk_i or negedge axis_aresetn_i) begin
        if (!axis_aresetn_i) begin
            state_reg       <= ST_SAMPLE;
            last_sample_reg <= '0;
            stable_reg      <= '0;
            pending_reg     <= '0;
            count_reg       <= '0;
            s_tready_reg    <= 1'b0;
            m_tvalid_reg    <= 1'b0;
            m_tdata_reg     <= '0;
        end else begin
            state_reg       <= state_next;
            last_sample_reg <= last_sample_next;
            stable_reg      <= stable_next;
            pending_reg     <= pending_next;
            count_reg       <= count_next;
            s_tready_reg    <= s_tready_next;
            m_tvalid_reg    <= m_tvalid_next;
            m_tdata_reg     <= m_tdata_next;
        end
    end

    assign s_axis_tready_o = s_tready_reg;
    assign m_axis_tvalid_o = m_tvalid_reg;
    assign m_axis_tdata_o  = m_tdata_reg;

endmodule

// File: tb/tb_axis_key_event.sv
// Scoreboard bench for axis_key_event: default 8-bit/4-sample instance plus a 16-bit/1-sample instance.
module tb_axis_key_event;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic        s_tvalid = 1'b0;
    logic        s_tready;
    logic [7:0]  s_tdata  = '0;
    logic        m_tvalid;
    logic        m_tready = 1'b1;
    logic [7:0]  m_tdata;

    logic        s_tvalid2 = 1'b0;
    logic        s_tready2;
    logic [15:0] s_tdata2  = '0;
    logic        m_tvalid2;
    logic        m_tready2 = 1'b1;
    logic [7:0]  m_tdata2;

    int checks    = 0;
    int failures  = 0;
    int ev_count  = 0;
    int e0;
    logic [7:0] exp_q[$];
    logic [7:0] exp2_q[$];

    axis_key_event #(.DATA_WIDTH(8), .DEBOUNCE_SAMPLES(4)) dut (
        .axis_aclk_i     (clk),
        .axis_aresetn_i  (rst_n),
        .s_axis_tvalid_i (s_tvalid),
        .s_axis_tready_o (s_tready),
        .s_axis_tdata_i  (s_tdata),
        .m_axis_tvalid_o (m_tvalid),
        .m_axis_tready_i (m_tready),
        .m_axis_tdata_o  (m_tdata)
    );

    axis_key_event #(.DATA_WIDTH(16), .DEBOUNCE_SAMPLES(1)) dut2 (
        .axis_aclk_i     (clk),
        .axis_aresetn_i  (rst_n),
        .s_axis_tvalid_i (s_tvalid2),
        .s_axis_tready_o (s_tready2),
        .s_axis_tdata_i  (s_tdata2),
        .m_axis_tvalid_o (m_tvalid2),
        .m_axis_tready_i (m_tready2),
        .m_axis_tdata_o  (m_tdata2)
    );

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%02h required=0x%02h", name, act, req);
        end else begin
            $display("ok   %s value=0x%02h", name, act);
        end
    endtask

    // Monitors: pop the expected event whenever a handshake is visible.
    initial forever begin
        @(negedge clk);
        if (rst_n && m_tvalid && m_tready) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_event actual=0x%02h required=none", m_tdata);
            end else begin
                check("event", m_tdata, exp_q.pop_front());
            end
            ev_count++;
        end
    end

    initial forever begin
        @(negedge clk);
        if (rst_n && m_tvalid2 && m_tready2) begin
            if (exp2_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_event2 actual=0x%02h required=none", m_tdata2);
            end else begin
                check("event2", m_tdata2, exp2_q.pop_front());
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [7:0] d);
        int n;
        s_tvalid = 1'b1;
        s_tdata  = d;
        n = 0;
        while (s_tready !== 1'b1 && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 50) check("send_timeout", {7'b0, s_tready}, 8'd1);
        @(posedge clk);
        #1;
        s_tvalid = 1'b0;
    endtask

    task automatic send2(input logic [15:0] d);
        int n;
        s_tvalid2 = 1'b1;
        s_tdata2  = d;
        n = 0;
        while (s_tready2 !== 1'b1 && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 50) check("send2_timeout", {7'b0, s_tready2}, 8'd1);
        @(posedge clk);
        #1;
        s_tvalid2 = 1'b0;
    endtask

    task automatic do_reset();
        s_tvalid  = 1'b0;
        s_tvalid2 = 1'b0;
        rst_n     = 1'b0;
        #1;
        check("rst_s_tready", {7'b0, s_tready}, 8'd0);
        check("rst_m_tvalid", {7'b0, m_tvalid}, 8'd0);
        check("rst_m_tdata", m_tdata, 8'h00);
        cycles(2);
        rst_n = 1'b1;
        cycles(1);
        check("tready_after_reset", {7'b0, s_tready}, 8'd1);
    endtask

    initial begin
        #2;
        // Press 0x05: events 0 and 2, upstream stalled for two cycles.
        do_reset();
        m_tready = 1'b1;
        exp_q.push_back(8'h00);
        exp_q.push_back(8'h02);
        e0 = ev_count;
        repeat (4) send(8'h05);
        check("t1_tready_low_c1", {7'b0, s_tready}, 8'd0);
        cycles(1);
        check("t1_tready_low_c2", {7'b0, s_tready}, 8'd0);
        cycles(1);
        check("t1_tready_back", {7'b0, s_tready}, 8'd1);
        check("t1_events", 8'(ev_count - e0), 8'd2);

        // Bounce restarts the count.
        do_reset();
        exp_q.push_back(8'h00);
        exp_q.push_back(8'h02);
        e0 = ev_count;
        send(8'h05); send(8'h00); send(8'h05); send(8'h05); send(8'h05);
        cycles(2);
        check("t2_no_event_yet", 8'(ev_count - e0), 8'd0);
        check("t2_tvalid_low", {7'b0, m_tvalid}, 8'd0);
        send(8'h05);
        cycles(3);
        check("t2_events", 8'(ev_count - e0), 8'd2);

        // Backpressure holds the first event.
        do_reset();
        m_tready = 1'b0;
        exp_q.push_back(8'h00);
        exp_q.push_back(8'h07);
        e0 = ev_count;
        repeat (4) send(8'h81);
        for (int i = 0; i < 5; i++) begin
            check("t3_hold_tvalid", {7'b0, m_tvalid}, 8'd1);
            check("t3_hold_tdata", m_tdata, 8'h00);
            check("t3_hold_s_tready", {7'b0, s_tready}, 8'd0);
            cycles(1);
        end
        m_tready = 1'b1;
        cycles(2);
        check("t3_tready_back", {7'b0, s_tready}, 8'd1);
        check("t3_events", 8'(ev_count - e0), 8'd2);

        // Release 0x81 -> 0x01.
        e0 = ev_count;
`ifdef KEY_RELEASE_EVENT_EN
        exp_q.push_back(8'h87);
        repeat (4) send(8'h01);
        check("t4_rel_tvalid", {7'b0, m_tvalid}, 8'd1);
        check("t4_rel_s_tready", {7'b0, s_tready}, 8'd0);
        cycles(2);
        check("t4_tready_back", {7'b0, s_tready}, 8'd1);
        check("t4_events", 8'(ev_count - e0), 8'd1);
`else
        repeat (4) send(8'h01);
        check("t4_no_rel_s_tready", {7'b0, s_tready}, 8'd1);
        check("t4_no_rel_tvalid", {7'b0, m_tvalid}, 8'd0);
        cycles(3);
        check("t4_s_tready_held", {7'b0, s_tready}, 8'd1);
        check("t4_events", 8'(ev_count - e0), 8'd0);
`endif

        // Reset mid-emission discards the three pending events.
        do_reset();
        m_tready = 1'b0;
        repeat (4) send(8'h07);
        cycles(1);
        check("t5_emit_tvalid", {7'b0, m_tvalid}, 8'd1);
        check("t5_emit_tdata", m_tdata, 8'h00);
        #2;
        rst_n = 1'b0;
        #1;
        check("t5_async_tvalid", {7'b0, m_tvalid}, 8'd0);
        check("t5_async_tdata", m_tdata, 8'h00);
        check("t5_async_s_tready", {7'b0, s_tready}, 8'd0);
        @(posedge clk);
        #1;
        rst_n    = 1'b1;
        m_tready = 1'b1;
        cycles(1);
        check("t5_tready_after", {7'b0, s_tready}, 8'd1);
        e0 = ev_count;
        cycles(5);
        check("t5_no_stale", 8'(ev_count - e0), 8'd0);
        check("t5_tvalid_idle", {7'b0, m_tvalid}, 8'd0);

        // 16-bit, single-sample debounce: key 15 one cycle after accept.
        exp2_q.push_back(8'h0F);
        send2(16'h8000);
        check("t6_tvalid", {7'b0, m_tvalid2}, 8'd1);
        check("t6_tdata", m_tdata2, 8'h0F);
        cycles(3);

        cycles(5);
        check("queue_empty", 8'(exp_q.size()), 8'd0);
        check("queue2_empty", 8'(exp2_q.size()), 8'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
